// File: rtl/breakout_pkg.sv
// Shared Breakout definitions: button count, button indices and the repeat FSM encoding.
package breakout_pkg;

  localparam int unsigned N_BTN  = 4;

  localparam int unsigned BTN_B2 = 0;
  localparam int unsigned BTN_B3 = 1;
  localparam int unsigned BTN_B4 = 2;
  localparam int unsigned BTN_B5 = 3;

  typedef enum logic [1:0] {
    RELEASED,
    DELAY,
    REPEAT
  } rep_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Raw button pins in, conditioned level and pulse vectors out.
interface button_conditioner_if;
  import breakout_pkg::*;

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_repeat;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_repeat
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_repeat
  );

endinterface

// File: rtl/button_channel.sv
// One button: two-flop synchroniser, debounce counter, press/release pulses and auto-repeat FSM.
module button_channel
  import breakout_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC     = 1_000_000,
  parameter int unsigned REPEAT_DELAY_CYC = 25_000_000,
  parameter int unsigned REPEAT_RATE_CYC  = 5_000_000,
  parameter bit          ACTIVE_LOW       = 1'b1
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYC);
  localparam int unsigned RW = $clog2(max_u(REPEAT_DELAY_CYC, REPEAT_RATE_CYC));

  localparam logic [DW-1:0] DCNT_LAST  = DW'(DEBOUNCE_CYC - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY_CYC - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE_CYC - 1);

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          press_q, release_q, repeat_q, repeat_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  rep_state_t    state_q, state_d;
  logic          rise, fall;

  always_comb begin
    dcnt_d  = dcnt_q;
    level_d = level_q;
    rise    = 1'b0;
    fall    = 1'b0;
    if (s2_q == level_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DCNT_LAST) begin
      dcnt_d  = '0;
      level_d = s2_q;
      rise    = s2_q;
      fall    = ~s2_q;
    end else begin
      dcnt_d = dcnt_q + DW'(1);
    end
  end

  // A release on the same edge a repeat falls due takes priority and suppresses the pulse.
  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    repeat_d = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (rise) begin
          repeat_d = 1'b1;
          rcnt_d   = '0;
          state_d  = DELAY;
        end
      end
      DELAY: begin
        if (fall) begin
          rcnt_d  = '0;
          state_d = RELEASED;
        end else if (rcnt_q == DELAY_LAST) begin
          repeat_d = 1'b1;
          rcnt_d   = '0;
          state_d  = REPEAT;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      REPEAT: begin
        if (fall) begin
          rcnt_d  = '0;
          state_d = RELEASED;
        end else if (rcnt_q == RATE_LAST) begin
          repeat_d = 1'b1;
          rcnt_d   = '0;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      default: begin
        rcnt_d  = '0;
        state_d = RELEASED;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      level_q   <= 1'b0;
      dcnt_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      rcnt_q    <= '0;
      state_q   <= RELEASED;
    end else begin
      s1_q      <= raw ^ ACTIVE_LOW;
      s2_q      <= s1_q;
      level_q   <= level_d;
      dcnt_q    <= dcnt_d;
      press_q   <= rise;
      release_q <= fall;
      repeat_q  <= repeat_d;
      rcnt_q    <= rcnt_d;
      state_q   <= state_d;
    end
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the four board push-buttons into clean levels, edge pulses and auto-repeat pulses.
module button_conditioner
  import breakout_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC     = 1_000_000,
  parameter int unsigned REPEAT_DELAY_CYC = 25_000_000,
  parameter int unsigned REPEAT_RATE_CYC  = 5_000_000,
  parameter bit          ACTIVE_LOW       = 1'b1
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  button_conditioner_if.slave bus
);

  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] rel;
  logic [N_BTN-1:0] rep;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYC     (DEBOUNCE_CYC),
      .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
      .REPEAT_RATE_CYC  (REPEAT_RATE_CYC),
      .ACTIVE_LOW       (ACTIVE_LOW)
    ) u_ch (
      .sys_clk       (sys_clk),
      .sys_rst_n     (sys_rst_n),
      .raw           (bus.btn_raw[i]),
      .level         (level[i]),
      .press_pulse   (press[i]),
      .release_pulse (rel[i]),
      .repeat_pulse  (rep[i])
    );
  end

  assign bus.btn_level   = level;
  assign bus.btn_press   = press;
  assign bus.btn_release = rel;
  assign bus.btn_repeat  = rep;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: table phases, directed corner cases and random holds vs a model.
module tb_button_conditioner;
  import breakout_pkg::*;

  localparam int unsigned DEB  = 8;
  localparam int unsigned DLY  = 20;
  localparam int unsigned RATE = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  button_conditioner_if bus ();

  button_conditioner #(
    .DEBOUNCE_CYC     (DEB),
    .REPEAT_DELAY_CYC (DLY),
    .REPEAT_RATE_CYC  (RATE),
    .ACTIVE_LOW       (1'b1)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_press, n_rel, n_rep;

  // Behavioural model: run = consecutive edges the synchronised value disagreed with the level,
  // t = edges since the press; repeats fall at t=0 and t = DLY + k*RATE while held.
  logic [N_BTN-1:0] m_s1, m_s2, m_lev;
  int               m_run [N_BTN];
  int               m_t   [N_BTN];
  logic [N_BTN-1:0] e_press, e_rel, e_rep;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lev = '0;
    e_press = '0; e_rel = '0; e_rep = '0;
    for (int i = 0; i < N_BTN; i++) begin
      m_run[i] = 0;
      m_t[i]   = 0;
    end
  endtask

  task automatic model_edge(input logic [N_BTN-1:0] raw);
    for (int i = 0; i < N_BTN; i++) begin
      e_press[i] = 1'b0; e_rel[i] = 1'b0; e_rep[i] = 1'b0;
      if (m_s2[i] != m_lev[i]) m_run[i]++;
      else m_run[i] = 0;
      if (m_run[i] == int'(DEB)) begin
        m_run[i] = 0;
        m_lev[i] = m_s2[i];
        if (m_lev[i]) e_press[i] = 1'b1;
        else e_rel[i] = 1'b1;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = ~raw[i];
      if (e_press[i]) begin
        m_t[i]   = 0;
        e_rep[i] = 1'b1;
      end else if (m_lev[i]) begin
        m_t[i]++;
        if (m_t[i] >= int'(DLY) && (m_t[i] - int'(DLY)) % int'(RATE) == 0) e_rep[i] = 1'b1;
      end
    end
  endtask

  task automatic report(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    logic [N_BTN-1:0] r;
    r = bus.btn_raw;
    @(posedge clk);
    #1;
    if (rst_n) model_edge(r);
    else model_reset();
    cyc++;
    report("level",   int'(bus.btn_level),   int'(m_lev));
    report("press",   int'(bus.btn_press),   int'(e_press));
    report("release", int'(bus.btn_release), int'(e_rel));
    report("repeat",  int'(bus.btn_repeat),  int'(e_rep));
    n_press += $countones(bus.btn_press);
    n_rel   += $countones(bus.btn_release);
    n_rep   += $countones(bus.btn_repeat);
  endtask

  task automatic wait_press(input int b, output int at);
    at = -1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (bus.btn_press[b]) begin
        at = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic [N_BTN-1:0] raw;
    int               cycles;
    logic [N_BTN-1:0] level;
    int               presses;
    int               releases;
    int               repeats;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int at;
    // Phases run back to back; counts are pulses summed over all bits within the phase.
    tbl[0] = '{raw: 4'hF, cycles: 15, level: 4'h0, presses: 0, releases: 0, repeats: 0};
    tbl[1] = '{raw: 4'hE, cycles: 12, level: 4'h1, presses: 1, releases: 0, repeats: 1};
    tbl[2] = '{raw: 4'hE, cycles: 30, level: 4'h1, presses: 0, releases: 0, repeats: 3};
    tbl[3] = '{raw: 4'hF, cycles: 12, level: 4'h0, presses: 0, releases: 1, repeats: 2};
    tbl[4] = '{raw: 4'h0, cycles: 12, level: 4'hF, presses: 4, releases: 0, repeats: 4};
    tbl[5] = '{raw: 4'hF, cycles: 12, level: 4'h0, presses: 0, releases: 4, repeats: 0};

    bus.btn_raw = 4'hF;
    model_reset();
    step();
    step();
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      n_press = 0; n_rel = 0; n_rep = 0;
      bus.btn_raw = tbl[v].raw;
      for (int c = 0; c < tbl[v].cycles; c++) step();
      report("tbl_level",    int'(bus.btn_level), int'(tbl[v].level));
      report("tbl_presses",  n_press, tbl[v].presses);
      report("tbl_releases", n_rel,   tbl[v].releases);
      report("tbl_repeats",  n_rep,   tbl[v].repeats);
    end

    // Bounce on B3: toggles every 3 cycles must never debounce.
    n_press = 0;
    for (int j = 0; j < 10; j++) begin
      bus.btn_raw = (j % 2 == 0) ? 4'hD : 4'hF;
      repeat (3) step();
    end
    report("bounce_no_press", n_press, 0);
    bus.btn_raw = 4'hD;
    wait_press(BTN_B3, at);
    report("bounce_latency", at, 10);

    // Release lands exactly on B4's first repeat-due edge.
    bus.btn_raw = 4'hF;
    repeat (15) step();
    bus.btn_raw = 4'hB;
    wait_press(BTN_B4, at);
    report("collision_press_latency", at, 10);
    repeat (10) step();
    bus.btn_raw = 4'hF;
    repeat (10) step();
    report("collision_release", int'(bus.btn_release[BTN_B4]), 1);
    report("collision_no_repeat", int'(bus.btn_repeat[BTN_B4]), 0);

    // Reset while B5 is auto-repeating; button stays held through and after reset.
    repeat (5) step();
    bus.btn_raw = 4'h7;
    wait_press(BTN_B5, at);
    report("hold_press_latency", at, 10);
    repeat (30) step();
    #2 rst_n = 1'b0;
    #1;
    report("reset_async_level", int'(bus.btn_level), 0);
    report("reset_async_pulses",
           int'({bus.btn_press, bus.btn_release, bus.btn_repeat}), 0);
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    n_press = 0; n_rel = 0; n_rep = 0;
    wait_press(BTN_B5, at);
    report("post_reset_latency", at, 2 + int'(DEB));
    report("post_reset_single_press", n_press, 1);
    report("post_reset_no_release", n_rel, 0);

    // Random holds, all bits independent, checked cycle by cycle against the model.
    for (int r = 0; r < 40; r++) begin
      bus.btn_raw = 4'($urandom);
      repeat ($urandom_range(1, 40)) step();
    end
    bus.btn_raw = 4'hF;
    repeat (15) step();
    report("final_level", int'(bus.btn_level), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Input-conditioning stage between the four board push-buttons (B2–B5) and the Breakout game core. Each raw button is synchronised into `sys_clk`, debounced, and turned into a clean level, single-cycle press/release pulses, and an auto-repeat pulse train for paddle movement. The game core consumes only these conditioned signals and never the raw pins.

## Interface
Parameters:
- `DEBOUNCE_CYC`, default 1_000_000: cycles a synchronised input must differ from the current level before the level flips (20 ms at 50 MHz); minimum 2.
- `REPEAT_DELAY_CYC`, default 25_000_000: hold cycles after a press before the first repeat pulse; minimum 2.
- `REPEAT_RATE_CYC`, default 5_000_000: cycles between subsequent repeat pulses; minimum 2.
- `ACTIVE_LOW`, default 1: 1 means a pressed pin reads 0.

Ports:
- `sys_clk` in 1: system clock, rising edge.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `btn_raw` in 4: asynchronous pins; bit0=B2, bit1=B3, bit2=B4, bit3=B5.
- `btn_level` out 4: debounced state; 1 = pressed.
- `btn_press` out 4: one-cycle pulse on each debounced 0→1.
- `btn_release` out 4: one-cycle pulse on each debounced 1→0.
- `btn_repeat` out 4: one-cycle pulse on press, then auto-repeat while held.

## Operation
- Four independent, identical channels; no cross-channel interaction.
- Polarity: `p = btn_raw[i] ^ ACTIVE_LOW`, so 1 = pressed.
- Synchroniser: two flops, `s1 <= p; s2 <= s1`. Both reset to 0 (not pressed).
- Debounce counter `dcnt` (width `$clog2(DEBOUNCE_CYC)`):
  - If `s2 == btn_level`: `dcnt <= 0`.
  - Else if `dcnt == DEBOUNCE_CYC-1`: `btn_level <= s2`, `dcnt <= 0`.
  - Else: `dcnt <= dcnt+1`.
- Any glitch shorter than `DEBOUNCE_CYC` cycles clears `dcnt` and causes no level change.
- `btn_press` and `btn_release` are registered. They assert in the same cycle `btn_level` first shows the new value and stay high for exactly one cycle.
- Repeat FSM per channel, counter `rcnt` sized for `max(REPEAT_DELAY_CYC, REPEAT_RATE_CYC)`:
  - RELEASED: on the level 0→1 update, pulse `btn_repeat` (coincident with `btn_press`), `rcnt <= 0`, go to DELAY.
  - DELAY: `rcnt` increments. At `rcnt == REPEAT_DELAY_CYC-1`: pulse, `rcnt <= 0`, go to REPEAT.
  - REPEAT: `rcnt` increments. At `rcnt == REPEAT_RATE_CYC-1`: pulse, `rcnt <= 0`, stay.
  - From DELAY or REPEAT: the debounced 1→0 update goes to RELEASED, `rcnt <= 0`, no repeat pulse.
- Release wins over a repeat pulse due in the same cycle.
- Counters never wrap: each is cleared on reaching its terminal value.

## Timing
- Reset values: all outputs 0, FSM RELEASED, all counters and sync flops 0.
- A button held through reset is detected normally: press pulse `2 + DEBOUNCE_CYC` cycles after reset release, no earlier pulse.
- Latency: a clean raw transition sampled at edge k gives `btn_level`/pulse visible after edge `k + 1 + DEBOUNCE_CYC` (two sync edges plus `DEBOUNCE_CYC` count edges, registered output).
- First repeat after press: `REPEAT_DELAY_CYC` cycles after the press pulse. Then one pulse every `REPEAT_RATE_CYC` cycles.
- Reset asserted mid-operation: all state clears asynchronously. No pulse is emitted on reset assertion or release.
- Simultaneous transitions on several buttons produce simultaneous, independent pulses.

## Structure
- Shared package `breakout_pkg`:
  - `N_BTN = 4`.
  - Repeat FSM enum `rep_state_t` {RELEASED, DELAY, REPEAT}.
  - Button index constants `BTN_B2..BTN_B5`.
- One sub-module, `button_channel`: synchroniser, debounce and repeat FSM for a single bit.
- `button_conditioner` instantiates `button_channel` four times via a generate loop and concatenates the outputs.

## Test plan
All scenarios use `DEBOUNCE_CYC=8`, `REPEAT_DELAY_CYC=20`, `REPEAT_RATE_CYC=5`, `ACTIVE_LOW=1`.
- Clean press: drive B2 low at cycle 0 and hold → `btn_level[0]=1`, with `btn_press[0]` and `btn_repeat[0]` single pulses at cycle 10; nothing on bits 1–3.
- Bounce: toggle B3 every 3 cycles for 30 cycles, then hold low → no pulse during the bounce; one press pulse 10 cycles after the final stable edge.
- Auto-repeat: hold B4 for 60 cycles after press → repeat pulses at press+0, +20, +25, +30, … through the hold; release gives one `btn_release` pulse and no further repeats.
- Release/repeat collision: time the release so the debounced 1→0 update lands on a repeat-due cycle → only `btn_release` pulses.
- Reset mid-hold: assert `sys_rst_n=0` during REPEAT with B5 held → all outputs 0 immediately; after release, press pulse at 10 cycles.
- Simultaneous: press all four buttons on the same cycle → four-bit `btn_press=4'hF` for exactly one cycle.
